// File: rtl/pwm_param_rx.sv
// Receives PWM parameter frames over a UDP AXI-Stream and converts frequency/duty
// into period and high-time cycle counts using a shared 40-bit restoring divider.
module pwm_param_rx #(
  parameter int unsigned PWM_NUM      = 5,
  parameter logic [7:0]  ID_PWM_PARAM = 8'd0,
  parameter int unsigned CLK_FREQ     = 100000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] rx_axis_udp_tdata,
  input  logic        rx_axis_udp_tvalid,
  input  logic        rx_axis_udp_tlast,
  input  logic [7:0]  rx_axis_udp_tuser,
  output logic        cfg_valid,
  output logic [7:0]  cfg_channel,
  output logic [31:0] cfg_period,
  output logic [31:0] cfg_high,
  output logic        cfg_en,
  output logic        busy,
  output logic        err
);

  localparam logic [31:0] FREQ_MAX  = 32'(CLK_FREQ / 2);
  localparam logic [39:0] DIVIDEND1 = 40'(CLK_FREQ);
  localparam logic [8:0]  CH_LIMIT  = 9'(PWM_NUM);

  typedef enum logic [2:0] {IDLE, RECV, DRAIN, DIV1, DIV2, OUT} state_t;

  state_t      state_q, state_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  ch_q, ch_d;
  logic [31:0] freq_q, freq_d;
  logic [6:0]  duty_q, duty_d;
  logic        en_q, en_d;
  logic        mid_q, mid_d;
  logic        drop_q, drop_d;
  logic        ld_q, ld_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [39:0] quo_q, quo_d;
  logic [31:0] rem_q, rem_d;
  logic [31:0] dvs_q, dvs_d;
  logic [31:0] period_q, period_d;
  logic        cfg_valid_q, cfg_valid_d;
  logic [7:0]  cfg_channel_q, cfg_channel_d;
  logic [31:0] cfg_period_q, cfg_period_d;
  logic [31:0] cfg_high_q, cfg_high_d;
  logic        cfg_en_q, cfg_en_d;
  logic        busy_q, busy_d;
  logic        err_q, err_d;

  logic [32:0] rem_sh;
  logic        q_bit;
  logic [31:0] rem_nx;
  logic [39:0] quo_nx;
  logic        first_beat, hit, busy_now, bad_frame;

  // One restoring-division step: shift in the next dividend bit, subtract if it fits.
  always_comb begin
    rem_sh = {rem_q, quo_q[39]};
    q_bit  = (rem_sh >= {1'b0, dvs_q});
    rem_nx = q_bit ? 32'(rem_sh - {1'b0, dvs_q}) : rem_sh[31:0];
    quo_nx = {quo_q[38:0], q_bit};
  end

  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    ch_d          = ch_q;
    freq_d        = freq_q;
    duty_d        = duty_q;
    en_d          = en_q;
    mid_d         = mid_q;
    drop_d        = drop_q;
    ld_d          = ld_q;
    cnt_d         = cnt_q;
    quo_d         = quo_q;
    rem_d         = rem_q;
    dvs_d         = dvs_q;
    period_d      = period_q;
    cfg_valid_d   = 1'b0;
    cfg_channel_d = cfg_channel_q;
    cfg_period_d  = cfg_period_q;
    cfg_high_d    = cfg_high_q;
    cfg_en_d      = cfg_en_q;
    err_d         = 1'b0;

    first_beat = rx_axis_udp_tvalid && !mid_q;
    hit        = first_beat && (rx_axis_udp_tuser == ID_PWM_PARAM);
    busy_now   = (state_q == DIV1) || (state_q == DIV2) || (state_q == OUT);
    bad_frame  = ({1'b0, ch_q} >= CH_LIMIT) || (freq_q == '0) || (freq_q > FREQ_MAX);

    if (rx_axis_udp_tvalid) mid_d = !rx_axis_udp_tlast;

    // Frames that begin during a calculation are swallowed whole, with err on their last beat.
    if (drop_q) begin
      if (rx_axis_udp_tvalid && rx_axis_udp_tlast) begin
        drop_d = 1'b0;
        err_d  = 1'b1;
      end
    end else if (busy_now && hit) begin
      if (rx_axis_udp_tlast) err_d  = 1'b1;
      else                   drop_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (hit) begin
          if (rx_axis_udp_tlast) begin
            err_d = 1'b1;
          end else begin
            ch_d    = rx_axis_udp_tdata[7:0];
            idx_d   = 3'd1;
            state_d = RECV;
          end
        end
      end
      RECV: begin
        if (rx_axis_udp_tvalid) begin
          idx_d = idx_q + 3'd1;
          case (idx_q)
            3'd1:    freq_d = rx_axis_udp_tdata;
            3'd2:    duty_d = (rx_axis_udp_tdata[6:0] > 7'd100) ? 7'd100 : rx_axis_udp_tdata[6:0];
            default: ;
          endcase
          if (idx_q == 3'd4) begin
            en_d = rx_axis_udp_tdata[0];
            if (!rx_axis_udp_tlast) begin
              err_d   = 1'b1;
              state_d = DRAIN;
            end else if (bad_frame) begin
              err_d   = 1'b1;
              state_d = IDLE;
            end else begin
              quo_d   = DIVIDEND1;
              rem_d   = '0;
              dvs_d   = freq_q;
              cnt_d   = '0;
              state_d = DIV1;
            end
          end else if (rx_axis_udp_tlast) begin
            err_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      DRAIN: begin
        if (rx_axis_udp_tvalid && rx_axis_udp_tlast) state_d = IDLE;
      end
      DIV1: begin
        quo_d = quo_nx;
        rem_d = rem_nx;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'd39) begin
          period_d = quo_nx[31:0];
          ld_d     = 1'b1;
          state_d  = DIV2;
        end
      end
      DIV2: begin
        // First DIV2 cycle registers the full 40-bit period*duty product before dividing by 100.
        if (ld_q) begin
          quo_d = 40'(period_q) * 40'(duty_q);
          rem_d = '0;
          dvs_d = 32'd100;
          cnt_d = '0;
          ld_d  = 1'b0;
        end else begin
          quo_d = quo_nx;
          rem_d = rem_nx;
          cnt_d = cnt_q + 6'd1;
          if (cnt_q == 6'd39) begin
            cfg_valid_d   = 1'b1;
            cfg_channel_d = ch_q;
            cfg_period_d  = period_q;
            cfg_high_d    = quo_nx[31:0];
            cfg_en_d      = en_q;
            state_d       = OUT;
          end
        end
      end
      OUT:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    busy_d = (state_d == DIV1) || (state_d == DIV2) || (state_d == OUT);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      ch_q          <= '0;
      freq_q        <= '0;
      duty_q        <= '0;
      en_q          <= 1'b0;
      mid_q         <= 1'b0;
      drop_q        <= 1'b0;
      ld_q          <= 1'b0;
      cnt_q         <= '0;
      quo_q         <= '0;
      rem_q         <= '0;
      dvs_q         <= '0;
      period_q      <= '0;
      cfg_valid_q   <= 1'b0;
      cfg_channel_q <= '0;
      cfg_period_q  <= '0;
      cfg_high_q    <= '0;
      cfg_en_q      <= 1'b0;
      busy_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      idx_q         <= idx_d;
      ch_q          <= ch_d;
      freq_q        <= freq_d;
      duty_q        <= duty_d;
      en_q          <= en_d;
      mid_q         <= mid_d;
      drop_q        <= drop_d;
      ld_q          <= ld_d;
      cnt_q         <= cnt_d;
      quo_q         <= quo_d;
      rem_q         <= rem_d;
      dvs_q         <= dvs_d;
      period_q      <= period_d;
      cfg_valid_q   <= cfg_valid_d;
      cfg_channel_q <= cfg_channel_d;
      cfg_period_q  <= cfg_period_d;
      cfg_high_q    <= cfg_high_d;
      cfg_en_q      <= cfg_en_d;
      busy_q        <= busy_d;
      err_q         <= err_d;
    end
  end

  assign cfg_valid   = cfg_valid_q;
  assign cfg_channel = cfg_channel_q;
  assign cfg_period  = cfg_period_q;
  assign cfg_high    = cfg_high_q;
  assign cfg_en      = cfg_en_q;
  assign busy        = busy_q;
  assign err         = err_q;

endmodule

// File: tb/tb_pwm_param_rx.sv
// Directed bench for pwm_param_rx: frame parsing, divider results, timing, rejects and reset abort.
module tb_pwm_param_rx;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic [7:0]  tuser = '0;
  logic        cfg_valid, cfg_en, busy, err;
  logic [7:0]  cfg_channel;
  logic [31:0] cfg_period, cfg_high;

  pwm_param_rx #(
    .PWM_NUM(5),
    .ID_PWM_PARAM(8'd0),
    .CLK_FREQ(100000000)
  ) dut (
    .clk(clk),
    .rst(rst),
    .rx_axis_udp_tdata(tdata),
    .rx_axis_udp_tvalid(tvalid),
    .rx_axis_udp_tlast(tlast),
    .rx_axis_udp_tuser(tuser),
    .cfg_valid(cfg_valid),
    .cfg_channel(cfg_channel),
    .cfg_period(cfg_period),
    .cfg_high(cfg_high),
    .cfg_en(cfg_en),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int tcyc = 0;
  int n_valid = 0, n_err = 0, n_busy = 0;
  int v_cyc = 0, e_cyc = 0;
  logic [7:0]  v_ch;
  logic [31:0] v_period, v_high;
  logic        v_en;
  int s_valid, s_err, s_busy;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (cfg_valid) begin
      n_valid++;
      v_cyc    = cyc;
      v_ch     = cfg_channel;
      v_period = cfg_period;
      v_high   = cfg_high;
      v_en     = cfg_en;
    end
    if (err) begin
      n_err++;
      e_cyc = cyc;
    end
    if (busy) n_busy++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [31:0] d, input logic l, input logic [7:0] u);
    @(negedge clk);
    tvalid = 1'b1;
    tdata  = d;
    tlast  = l;
    tuser  = u;
    tcyc   = cyc + 1;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      tvalid = 1'b0;
      tlast  = 1'b0;
    end
  endtask

  task automatic frame5(input logic [7:0] ch, input logic [31:0] freq, input logic [6:0] duty,
                        input logic en, input logic [7:0] u);
    beat({24'hAB1200, ch}, 1'b0, u);
    beat(freq, 1'b0, 8'h5A);
    beat({25'h0, duty}, 1'b0, 8'h5A);
    beat(32'hDEADBEEF, 1'b0, 8'h5A);
    beat({31'h0, en}, 1'b1, 8'h5A);
  endtask

  task automatic snap();
    s_valid = n_valid;
    s_err   = n_err;
    s_busy  = n_busy;
  endtask

  task automatic expect_cfg(input string tag, input logic [7:0] ch, input logic [31:0] period,
                            input logic [31:0] high, input logic en);
    int t0;
    t0 = tcyc;
    idle(100);
    chk({tag, "_nvalid"}, 64'(n_valid - s_valid), 64'd1);
    chk({tag, "_latency"}, 64'(v_cyc - t0), 64'd81);
    chk({tag, "_channel"}, 64'(v_ch), 64'(ch));
    chk({tag, "_period"}, 64'(v_period), 64'(period));
    chk({tag, "_high"}, 64'(v_high), 64'(high));
    chk({tag, "_en"}, 64'(v_en), 64'(en));
    chk({tag, "_nerr"}, 64'(n_err - s_err), 64'd0);
    chk({tag, "_busy_cycles"}, 64'(n_busy - s_busy), 64'd82);
  endtask

  task automatic expect_reject(input string tag);
    int t0;
    t0 = tcyc;
    idle(100);
    chk({tag, "_nerr"}, 64'(n_err - s_err), 64'd1);
    chk({tag, "_err_time"}, 64'(e_cyc - t0), 64'd0);
    chk({tag, "_nvalid"}, 64'(n_valid - s_valid), 64'd0);
  endtask

  initial begin
    int t1;
    @(negedge clk);
    chk("rst_valid", 64'(cfg_valid), 64'd0);
    chk("rst_channel", 64'(cfg_channel), 64'd0);
    chk("rst_period", 64'(cfg_period), 64'd0);
    chk("rst_high", 64'(cfg_high), 64'd0);
    chk("rst_en", 64'(cfg_en), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    rst = 1'b0;
    idle(3);

    snap(); frame5(8'd0, 32'd100000, 7'd100, 1'b1, 8'd0);
    expect_cfg("f100pct", 8'd0, 32'd1000, 32'd1000, 1'b1);
    chk("hold_period", 64'(cfg_period), 64'd1000);
    chk("hold_valid_low", 64'(cfg_valid), 64'd0);

    snap(); frame5(8'd1, 32'd333333, 7'd80, 1'b1, 8'd0);
    expect_cfg("f80pct", 8'd1, 32'd300, 32'd240, 1'b1);
    snap(); frame5(8'd2, 32'd100000, 7'd50, 1'b0, 8'd0);
    expect_cfg("f50pct_en0", 8'd2, 32'd1000, 32'd500, 1'b0);
    snap(); frame5(8'd4, 32'd100000, 7'd0, 1'b1, 8'd0);
    expect_cfg("f0pct", 8'd4, 32'd1000, 32'd0, 1'b1);
    snap(); frame5(8'd3, 32'd200000, 7'd120, 1'b1, 8'd0);
    expect_cfg("clamp120", 8'd3, 32'd500, 32'd500, 1'b1);
    snap(); frame5(8'd3, 32'd50000000, 7'd50, 1'b1, 8'd0);
    expect_cfg("fmax", 8'd3, 32'd2, 32'd1, 1'b1);
    snap(); frame5(8'd1, 32'd1, 7'd99, 1'b1, 8'd0);
    expect_cfg("wide_product", 8'd1, 32'd100000000, 32'd99000000, 1'b1);

    snap(); frame5(8'd5, 32'd100000, 7'd50, 1'b1, 8'd0);
    expect_reject("bad_channel");
    snap(); frame5(8'd0, 32'd0, 7'd50, 1'b1, 8'd0);
    expect_reject("freq_zero");
    snap(); frame5(8'd0, 32'd60000000, 7'd50, 1'b1, 8'd0);
    expect_reject("freq_high");

    snap();
    beat(32'd2, 1'b0, 8'd0);
    beat(32'd100000, 1'b0, 8'h00);
    beat(32'd50, 1'b1, 8'h00);
    expect_reject("short_frame");

    snap();
    frame5(8'd7, 32'd100000, 7'd50, 1'b1, 8'h07);
    idle(100);
    chk("foreign_nvalid", 64'(n_valid - s_valid), 64'd0);
    chk("foreign_nerr", 64'(n_err - s_err), 64'd0);

    snap();
    beat(32'd2, 1'b0, 8'd0);
    beat(32'd100000, 1'b0, 8'd0);
    beat(32'd50, 1'b0, 8'd0);
    beat(32'd0, 1'b0, 8'd0);
    beat(32'd1, 1'b0, 8'd0);
    t1 = tcyc;
    beat(32'd0, 1'b0, 8'd0);
    beat(32'd0, 1'b1, 8'd0);
    idle(100);
    chk("long_nerr", 64'(n_err - s_err), 64'd1);
    chk("long_err_time", 64'(e_cyc - t1), 64'd0);
    chk("long_nvalid", 64'(n_valid - s_valid), 64'd0);
    snap(); frame5(8'd1, 32'd333333, 7'd80, 1'b1, 8'd0);
    expect_cfg("after_drain", 8'd1, 32'd300, 32'd240, 1'b1);

    snap();
    frame5(8'd0, 32'd100000, 7'd100, 1'b1, 8'd0);
    t1 = tcyc;
    idle(10);
    frame5(8'd2, 32'd200000, 7'd50, 1'b0, 8'd0);
    idle(100);
    chk("ovl_nvalid", 64'(n_valid - s_valid), 64'd1);
    chk("ovl_latency", 64'(v_cyc - t1), 64'd81);
    chk("ovl_channel", 64'(v_ch), 64'd0);
    chk("ovl_period", 64'(v_period), 64'd1000);
    chk("ovl_nerr", 64'(n_err - s_err), 64'd1);
    chk("ovl_err_time", 64'(e_cyc - tcyc), 64'd0);
    chk("ovl_busy_cycles", 64'(n_busy - s_busy), 64'd82);

    snap(); frame5(8'd3, 32'd200000, 7'd25, 1'b1, 8'd0);
    expect_cfg("pre_reset", 8'd3, 32'd500, 32'd125, 1'b1);

    snap();
    frame5(8'd1, 32'd100000, 7'd50, 1'b1, 8'd0);
    idle(20);
    rst = 1'b1;
    #1;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_channel", 64'(cfg_channel), 64'd0);
    chk("abort_period", 64'(cfg_period), 64'd0);
    chk("abort_high", 64'(cfg_high), 64'd0);
    chk("abort_en", 64'(cfg_en), 64'd0);
    chk("abort_valid", 64'(cfg_valid), 64'd0);
    chk("abort_err", 64'(err), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(100);
    chk("abort_nvalid", 64'(n_valid - s_valid), 64'd0);
    snap(); frame5(8'd4, 32'd400000, 7'd40, 1'b1, 8'd0);
    expect_cfg("post_reset", 8'd4, 32'd250, 32'd100, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
